// File: rtl/hazard_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller: shadow
// scoreboard entry layout, register index width and the x0 index.
package hazard_ctrl_pkg;

    localparam int REG_IDX_W = 5;
    localparam logic [REG_IDX_W-1:0] X0_IDX = '0;

    typedef struct packed {
        logic                 valid;
        logic [REG_IDX_W-1:0] rd;
    } sb_entry_t;

    localparam sb_entry_t SB_EMPTY = '{valid: 1'b0, rd: X0_IDX};

    // An entry only blocks a reader if it really writes a register other than x0.
    function automatic logic sbMatch(
        input sb_entry_t            e,
        input logic [REG_IDX_W-1:0] rs1,
        input logic                 rs1Used,
        input logic [REG_IDX_W-1:0] rs2,
        input logic                 rs2Used
    );
        return e.valid && (e.rd != X0_IDX) &&
               ((rs1Used && (rs1 == e.rd)) || (rs2Used && (rs2 == e.rd)));
    endfunction

endpackage

// File: rtl/hazard_ctrl_sat_counter.sv
// Event counter that sticks at all-ones instead of wrapping; async active-low reset.
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc_i,
    output logic [CNT_W-1:0] count_o
);

    logic [CNT_W-1:0] count_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_q <= '0;
        end else if (inc_i && !(&count_q)) begin
            count_q <= count_q + CNT_W'(1);
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/hazard_ctrl.sv
// RAW hazard / flush controller for a 5-stage pipeline without forwarding.
// Tracks in-flight destinations in a shadow pipeline and counts stall/flush cycles.
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter bit WRITE_THROUGH = 1'b1,
    parameter int CNT_W         = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 id_have_inst,
    input  logic [REG_IDX_W-1:0] id_rs1,
    input  logic [REG_IDX_W-1:0] id_rs2,
    input  logic                 id_rs1_used,
    input  logic                 id_rs2_used,
    input  logic [REG_IDX_W-1:0] id_rd,
    input  logic                 id_rf_WE,
    input  logic                 ex_branch_taken,
    input  logic                 ex_j_type,
    output logic                 stop,
    output logic                 jump,
    output logic                 pc_hold,
    output logic                 ifid_hold,
    output logic [CNT_W-1:0]     stall_cnt,
    output logic [CNT_W-1:0]     flush_cnt
);

    sb_entry_t sbEx_q, sbMem_q, sbWb_q;
    sb_entry_t sbEx_d;
    logic      hazard;

    // A producer in WB only matters when the register file cannot bypass its own write.
    always_comb begin
        hazard = 1'b0;
        if (id_have_inst) begin
            hazard = sbMatch(sbEx_q,  id_rs1, id_rs1_used, id_rs2, id_rs2_used) ||
                     sbMatch(sbMem_q, id_rs1, id_rs1_used, id_rs2, id_rs2_used) ||
                     (!WRITE_THROUGH &&
                      sbMatch(sbWb_q, id_rs1, id_rs1_used, id_rs2, id_rs2_used));
        end
    end

    assign jump      = ex_branch_taken | ex_j_type;
    assign stop      = hazard & ~jump;
    assign pc_hold   = stop;
    assign ifid_hold = stop;

    always_comb begin
        sbEx_d = SB_EMPTY;
        if (!(jump || stop)) begin
            sbEx_d.valid = id_have_inst & id_rf_WE & (id_rd != X0_IDX);
            sbEx_d.rd    = id_rd;
        end
    end

    // EX onward is never flushed, so older entries always advance.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sbEx_q  <= SB_EMPTY;
            sbMem_q <= SB_EMPTY;
            sbWb_q  <= SB_EMPTY;
        end else begin
            sbEx_q  <= sbEx_d;
            sbMem_q <= sbEx_q;
            sbWb_q  <= sbMem_q;
        end
    end

    sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .clk     (clk),
        .reset   (reset),
        .inc_i   (stop),
        .count_o (stall_cnt)
    );

    sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
        .clk     (clk),
        .reset   (reset),
        .inc_i   (jump),
        .count_o (flush_cnt)
    );

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: three instances (write-through, no write-through,
// 3-bit counters) each driven by their own stimulus lanes.
module tb_hazard_ctrl;

    logic       clk;
    logic       reset;
    logic       haveInst [3];
    logic [4:0] rs1      [3];
    logic [4:0] rs2      [3];
    logic       rs1Used  [3];
    logic       rs2Used  [3];
    logic [4:0] rd       [3];
    logic       rfWe     [3];
    logic       brTaken  [3];
    logic       jType    [3];
    logic       stopO    [3];
    logic       jumpO    [3];
    logic       pcHold   [3];
    logic       ifidHold [3];
    logic [15:0] stallCnt0, flushCnt0, stallCnt1, flushCnt1;
    logic [2:0]  stallCnt2, flushCnt2;

    int compared   = 0;
    int mismatched = 0;

    hazard_ctrl #(.WRITE_THROUGH(1'b1), .CNT_W(16)) dutWt (
        .clk(clk), .reset(reset),
        .id_have_inst(haveInst[0]), .id_rs1(rs1[0]), .id_rs2(rs2[0]),
        .id_rs1_used(rs1Used[0]), .id_rs2_used(rs2Used[0]),
        .id_rd(rd[0]), .id_rf_WE(rfWe[0]),
        .ex_branch_taken(brTaken[0]), .ex_j_type(jType[0]),
        .stop(stopO[0]), .jump(jumpO[0]), .pc_hold(pcHold[0]), .ifid_hold(ifidHold[0]),
        .stall_cnt(stallCnt0), .flush_cnt(flushCnt0)
    );

    hazard_ctrl #(.WRITE_THROUGH(1'b0), .CNT_W(16)) dutNoWt (
        .clk(clk), .reset(reset),
        .id_have_inst(haveInst[1]), .id_rs1(rs1[1]), .id_rs2(rs2[1]),
        .id_rs1_used(rs1Used[1]), .id_rs2_used(rs2Used[1]),
        .id_rd(rd[1]), .id_rf_WE(rfWe[1]),
        .ex_branch_taken(brTaken[1]), .ex_j_type(jType[1]),
        .stop(stopO[1]), .jump(jumpO[1]), .pc_hold(pcHold[1]), .ifid_hold(ifidHold[1]),
        .stall_cnt(stallCnt1), .flush_cnt(flushCnt1)
    );

    hazard_ctrl #(.WRITE_THROUGH(1'b1), .CNT_W(3)) dutSat (
        .clk(clk), .reset(reset),
        .id_have_inst(haveInst[2]), .id_rs1(rs1[2]), .id_rs2(rs2[2]),
        .id_rs1_used(rs1Used[2]), .id_rs2_used(rs2Used[2]),
        .id_rd(rd[2]), .id_rf_WE(rfWe[2]),
        .ex_branch_taken(brTaken[2]), .ex_j_type(jType[2]),
        .stop(stopO[2]), .jump(jumpO[2]), .pc_hold(pcHold[2]), .ifid_hold(ifidHold[2]),
        .stall_cnt(stallCnt2), .flush_cnt(flushCnt2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic applyStimulus(input int k, input logic have,
                                 input logic [4:0] r1, input logic u1,
                                 input logic [4:0] r2, input logic u2,
                                 input logic [4:0] d, input logic we,
                                 input logic br, input logic jt);
        haveInst[k] = have;
        rs1[k]      = r1;
        rs1Used[k]  = u1;
        rs2[k]      = r2;
        rs2Used[k]  = u2;
        rd[k]       = d;
        rfWe[k]     = we;
        brTaken[k]  = br;
        jType[k]    = jt;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        compared++;
        assert (observed === expected) else begin
            mismatched++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    task automatic idleAll();
        for (int k = 0; k < 3; k++) applyStimulus(k, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        idleAll();
        repeat (4) tick();
    endtask

    initial begin
        int total;
        int guard;
        reset = 1'b0;
        idleAll();

        // Reset with random ID traffic: shadow is empty so nothing can stall.
        for (int c = 0; c < 4; c++) begin
            for (int k = 0; k < 3; k++)
                applyStimulus(k, 1'($urandom()), 5'($urandom()), 1'($urandom()),
                              5'($urandom()), 1'($urandom()), 5'($urandom()),
                              1'($urandom()), 1'($urandom()), 1'($urandom()));
            #1;
            for (int k = 0; k < 3; k++) checkOutput($sformatf("rst_stop%0d", k), stopO[k], 0);
            tick();
        end
        idleAll();
        #1;
        checkOutput("rst_jump", jumpO[0], 0);
        checkOutput("rst_stall0", stallCnt0, 0);
        checkOutput("rst_flush0", flushCnt0, 0);
        checkOutput("rst_stall2", stallCnt2, 0);
        checkOutput("rst_flush2", flushCnt2, 0);
        #2 reset = 1'b1;
        tick();
        applyStimulus(1, 1, 5'd17, 1, 5'd23, 1, 0, 0, 0, 0);
        #1;
        checkOutput("post_rst_no_hazard", stopO[1], 0);
        checkOutput("post_rst_stall1", stallCnt1, 0);
        drain();

        // RAW with write-through register file: 2 stop cycles.
        applyStimulus(0, 1, 0, 0, 0, 0, 5'd5, 1, 0, 0); #1;
        checkOutput("wt_prod_stop", stopO[0], 0);
        tick();
        applyStimulus(0, 1, 5'd5, 1, 5'd1, 1, 5'd6, 1, 0, 0); #1;
        checkOutput("wt_stop_c1", stopO[0], 1);
        checkOutput("wt_pc_hold", pcHold[0], 1);
        checkOutput("wt_ifid_hold", ifidHold[0], 1);
        tick(); checkOutput("wt_stop_c2", stopO[0], 1);
        tick(); checkOutput("wt_stop_c3", stopO[0], 0);
        tick(); idleAll(); #1;
        checkOutput("wt_stall_cnt", stallCnt0, 2);
        drain();

        // Same sequence without write-through: 3 stop cycles.
        applyStimulus(1, 1, 0, 0, 0, 0, 5'd5, 1, 0, 0); tick();
        applyStimulus(1, 1, 5'd5, 1, 5'd1, 1, 5'd6, 1, 0, 0); #1;
        checkOutput("nowt_stop_c1", stopO[1], 1);
        checkOutput("nowt_ifid_hold", ifidHold[1], 1);
        tick(); checkOutput("nowt_stop_c2", stopO[1], 1);
        tick(); checkOutput("nowt_stop_c3", stopO[1], 1);
        checkOutput("nowt_pc_hold_c3", pcHold[1], 1);
        tick(); checkOutput("nowt_stop_c4", stopO[1], 0);
        tick(); idleAll(); #1;
        checkOutput("nowt_stall_cnt", stallCnt1, 3);
        drain();

        // Producer already in MEM when the reader arrives: 1 stop cycle.
        applyStimulus(0, 1, 0, 0, 0, 0, 5'd5, 1, 0, 0); tick();
        applyStimulus(0, 1, 0, 0, 0, 0, 5'd9, 0, 0, 0); tick();
        applyStimulus(0, 1, 0, 0, 5'd5, 1, 0, 0, 0, 0); #1;
        checkOutput("mem_stop_c1", stopO[0], 1);
        tick(); checkOutput("mem_stop_c2", stopO[0], 0);
        tick(); idleAll(); #1;
        checkOutput("mem_stall_cnt", stallCnt0, 3);
        drain();

        // x0 writer/reader and an unused rs2 never stall.
        applyStimulus(0, 1, 0, 0, 0, 0, 0, 1, 0, 0); tick();
        applyStimulus(0, 1, 0, 1, 0, 1, 0, 0, 0, 0); #1;
        checkOutput("x0_no_stall", stopO[0], 0);
        tick();
        applyStimulus(0, 1, 0, 0, 0, 0, 5'd5, 1, 0, 0); tick();
        applyStimulus(0, 1, 5'd1, 1, 5'd5, 0, 0, 0, 0, 0); #1;
        checkOutput("rs2_unused_no_stall", stopO[0], 0);
        drain();

        // Jump wins over a simultaneous RAW hazard and bubbles the ID instruction.
        applyStimulus(0, 1, 0, 0, 0, 0, 5'd5, 1, 0, 0); tick();
        applyStimulus(0, 1, 5'd5, 1, 0, 0, 5'd8, 1, 0, 1); #1;
        checkOutput("jh_jump", jumpO[0], 1);
        checkOutput("jh_stop", stopO[0], 0);
        checkOutput("jh_pc_hold", pcHold[0], 0);
        tick();
        applyStimulus(0, 1, 5'd8, 1, 0, 0, 0, 0, 0, 0); #1;
        checkOutput("jh_sbex_invalid", stopO[0], 0);
        checkOutput("jh_flush_cnt", flushCnt0, 1);
        checkOutput("jh_stall_cnt", stallCnt0, 3);
        drain();

        // Three taken branches in ten cycles; flushed x7 writer must not stall its reader.
        for (int c = 0; c < 10; c++) begin
            logic br;
            br = (c == 0) || (c == 3) || (c == 6);
            if (c == 3)      applyStimulus(0, 1, 0, 0, 0, 0, 5'd7, 1, br, 0);
            else if (c == 4) applyStimulus(0, 1, 5'd7, 1, 0, 0, 0, 0, br, 0);
            else             applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, br, 0);
            #1;
            checkOutput($sformatf("br_jump_c%0d", c), jumpO[0], br);
            if (c == 4) checkOutput("br_x7_no_stall", stopO[0], 0);
            tick();
        end
        idleAll(); #1;
        checkOutput("br_flush_cnt", flushCnt0, 4);
        checkOutput("br_stall_cnt", stallCnt0, 3);

        // Dependent chain giving 10 stall cycles on a 3-bit counter.
        total = 0;
        for (int i = 0; i < 6; i++) begin
            applyStimulus(2, 1, 5'(4 + i), (i > 0), 0, 0, 5'(5 + i), 1, 0, 0);
            #1;
            guard = 0;
            while (stopO[2] && guard < 8) begin
                tick();
                guard++;
            end
            total += guard;
            tick();
        end
        idleAll(); #1;
        checkOutput("sat_stall_cycles", total, 10);
        checkOutput("sat_stall_cnt", stallCnt2, 7);
        checkOutput("sat_flush_cnt", flushCnt2, 0);
        drain();

        // Asynchronous reset in the middle of a stall.
        applyStimulus(2, 1, 0, 0, 0, 0, 5'd5, 1, 0, 0); tick();
        applyStimulus(2, 1, 5'd5, 1, 0, 0, 5'd6, 1, 0, 0); #1;
        checkOutput("mid_rst_pre_stop", stopO[2], 1);
        #2 reset = 1'b0;
        #1;
        checkOutput("mid_rst_stop", stopO[2], 0);
        checkOutput("mid_rst_stall2", stallCnt2, 0);
        checkOutput("mid_rst_stall0", stallCnt0, 0);
        checkOutput("mid_rst_flush0", flushCnt0, 0);
        tick();
        #3 reset = 1'b1;
        #1;
        checkOutput("post_mid_rst_stop", stopO[2], 0);
        tick();
        checkOutput("post_mid_rst_stall2", stallCnt2, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Pipeline hazard controller for the 5-stage RV32I pipelined CPU (IF/ID/EX/MEM/WB) with no forwarding network.
- Produces the `stop` (stall/bubble) and `jump` (flush) controls consumed by the ID/EX pipeline register, plus the matching controls for the PC and the IF/ID register.
- Keeps its own shadow pipeline of in-flight destination registers, detects RAW hazards against the instruction in ID, and counts stall and flush events.

Parameters:
- WRITE_THROUGH, 1, 1 = register file forwards a same-cycle WB write to ID reads, so a producer in WB is not a hazard; 0 = WB is a hazard.
- CNT_W, 16, width of the stall and flush event counters.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset (negedge).
- id_have_inst  input  1  ID stage holds a valid instruction.
- id_rs1  input  5  ID source register 1 index.
- id_rs2  input  5  ID source register 2 index.
- id_rs1_used  input  1  instruction reads rs1.
- id_rs2_used  input  1  instruction reads rs2.
- id_rd  input  5  ID destination register index.
- id_rf_WE  input  1  ID instruction writes the register file.
- ex_branch_taken  input  1  EX branch resolved as taken.
- ex_j_type  input  1  EX holds jal/jalr.
- stop  output  1  insert bubble into ID/EX.
- jump  output  1  flush IF/ID and ID/EX; PC takes the redirect.
- pc_hold  output  1  PC register keeps its value.
- ifid_hold  output  1  IF/ID register keeps its value.
- stall_cnt  output  CNT_W  cycles in which stop was asserted.
- flush_cnt  output  CNT_W  cycles in which jump was asserted.

Behaviour:
- Shadow entries sb_ex, sb_mem, sb_wb each hold {valid, rd[4:0]}. They mirror the write-back destinations of the EX, MEM and WB stages.
- Reset (asynchronous, reset == 0): all shadow valid bits = 0 and rd = 0; stall_cnt = 0; flush_cnt = 0.
  - stop, jump, pc_hold and ifid_hold are combinational, so they evaluate to 0 during reset because all shadow entries are invalid. The EX inputs are don't-care while in reset.
- jump = ex_branch_taken | ex_j_type. It is purely combinational from EX.
- Hazard condition: id_have_inst AND a match against any valid shadow entry with rd != 0, where a match is either:
  - id_rs1_used & id_rs1 == sb.rd, or
  - id_rs2_used & id_rs2 == sb.rd.
  - Entries checked: sb_ex and sb_mem always; sb_wb only when WRITE_THROUGH = 0.
  - x0 never causes a hazard.
- stop = hazard & ~jump. jump has priority, because the instruction in ID is discarded anyway.
- pc_hold = stop; ifid_hold = stop.
- Shadow update on each rising clk edge (reset high):
  - sb_ex is invalidated if jump | stop (bubble). Otherwise it takes valid = id_have_inst & id_rf_WE & (id_rd != 0), rd = id_rd.
  - sb_mem <= sb_ex and sb_wb <= sb_mem unconditionally. The EX instruction itself is never flushed, so a jal rd result continues to WB.
- Stall latency with the producer just entered into EX and the consumer in ID:
  - WRITE_THROUGH = 1: 2 stop cycles.
  - WRITE_THROUGH = 0: 3 stop cycles.
  - Producer in MEM: 1 cycle less in each case.
- Counters:
  - stall_cnt increments on each clk edge where stop = 1.
  - flush_cnt increments on each clk edge where jump = 1.
  - Both saturate at all-ones; no wrap-around.
- Simultaneous jump and hazard: jump = 1, stop = 0. flush_cnt increments; stall_cnt does not.
- Reset asserted mid-stall: all state clears immediately. After release, the first instruction sees no hazard.
- Back-to-back producers to the same rd: matches against either entry stall. The stall ends only when no valid matching entry remains.

Decomposition:
- Shared package holds:
  - REG_IDX_W = 5.
  - A shadow-entry struct {valid, rd}.
  - The constant X0_IDX = 0.
- One natural sub-module: sat_counter (CNT_W parameter, inc input, async active-low reset). It is instantiated twice.

Test Plan:
- Reset: hold reset = 0 with random inputs, release → stop = 0, jump = 0, stall_cnt = 0, flush_cnt = 0; all shadow entries invalid.
- RAW stall:
  - Stimulus: `addi x5,...` (id_rd = 5, id_rf_WE = 1) followed by `add x6,x5,x1` (rs1 = 5, rs1_used = 1).
  - WRITE_THROUGH = 1 → stop = 1 for exactly 2 cycles, stall_cnt = 2.
  - WRITE_THROUGH = 0 → stop = 1 for exactly 3 cycles, stall_cnt = 3.
- x0 / unused operand:
  - Producer writes x0, consumer reads x0 → stop never asserts.
  - Consumer with rs2 = 5 but rs2_used = 0 → no stall.
- Jump during hazard: ex_j_type = 1 in the same cycle a RAW hazard exists → jump = 1, stop = 0, flush_cnt = 1. The next-cycle sb_ex is invalid.
- Taken branch flush: ex_branch_taken pulsed 3 times over 10 cycles → flush_cnt = 3. A flushed ID instruction writing x7 does not stall a later reader of x7.
- Saturation and reset:
  - CNT_W = 3 with a sustained stall of 10 cycles → stall_cnt holds at 7.
  - Assert reset mid-stall → counters = 0 and stop = 0 asynchronously.
